// File: rtl/axi_bridge_pkg.sv
// Shared types and constants for the N-port SRAM-like to AXI3 bridge.
package axi_bridge_pkg;

  localparam int unsigned AXI_ID_W    = 4;
  localparam int unsigned WORD_ADDR_W = 30;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  typedef enum logic [2:0] {
    AXI_SIZE_BYTE = 3'd0,
    AXI_SIZE_HALF = 3'd1,
    AXI_SIZE_WORD = 3'd2
  } axi_size_t;

  // One in-flight write: owning port and the word it targets, for RAW blocking.
  typedef struct packed {
    logic                   valid;
    logic [AXI_ID_W-1:0]    id;
    logic [WORD_ADDR_W-1:0] word_addr;
  } wr_entry_t;

endpackage

// File: rtl/axi_sram_bridge_if.sv
// AXI3 master-port bundle of the core; the master drives AR/AW/W and the R/B readies.
interface axi_sram_bridge_if;
  import axi_bridge_pkg::*;

  logic [AXI_ID_W-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  axi_size_t           arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;

  logic [AXI_ID_W-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [AXI_ID_W-1:0] awid;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  axi_size_t           awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;

  logic [AXI_ID_W-1:0] wid;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [AXI_ID_W-1:0] bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/bridge_arbiter.sv
// Request arbiter for the bridge: fixed priority (lowest index) by default,
// round-robin when AXI_BRIDGE_RR_ARB_EN is defined.
module bridge_arbiter #(
  parameter  int unsigned N_PORTS = 2,
  localparam int unsigned PTR_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_PORTS-1:0] req,
  input  logic               accept,
  output logic [N_PORTS-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx
);

  logic [PTR_W-1:0] start;
  logic             found;

`ifdef AXI_BRIDGE_RR_ARB_EN
  logic [PTR_W-1:0] ptr;

  assign start = ptr;

  // Pointer moves past the winner only when the winner was actually accepted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (32'(grant_idx) == N_PORTS - 1) ? '0 : grant_idx + PTR_W'(1);
    end
  end
`else
  logic unused_rr;

  assign start     = '0;
  assign unused_rr = ^{clk, resetn, accept};
`endif

  // First requester at or after the start index wins, whether or not it is eligible.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (!found && req[PTR_W'((32'(start) + i) % N_PORTS)]) begin
        found     = 1'b1;
        grant_idx = PTR_W'((32'(start) + i) % N_PORTS);
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/axi_sram_bridge.sv
// N-port SRAM-like to AXI3 master bridge with per-port outstanding reads and a
// write-address table that blocks RAW hazards. AXI_BRIDGE_RR_ARB_EN selects round-robin.
module axi_sram_bridge
  import axi_bridge_pkg::*;
#(
  parameter int unsigned N_PORTS        = 2,
  parameter int unsigned RD_OUTSTANDING = 4,
  parameter int unsigned WR_DEPTH       = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [N_PORTS-1:0]      req,
  input  logic [N_PORTS-1:0]      wr,
  input  logic [N_PORTS-1:0][1:0] size,
  input  logic [N_PORTS-1:0][3:0] wstrb,
  input  logic [N_PORTS-1:0][31:0] addr,
  input  logic [N_PORTS-1:0][31:0] wdata,
  output logic [N_PORTS-1:0]      addr_ok,
  output logic [N_PORTS-1:0]      data_ok,
  output logic [N_PORTS-1:0][31:0] rdata,
  axi_sram_bridge_if.master       axi
);

  localparam int unsigned PTR_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned RCNT_W = $clog2(RD_OUTSTANDING + 1);
  localparam int unsigned WCNT_W = $clog2(WR_DEPTH + 1);

  logic [N_PORTS-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               accept, rd_acc, wr_acc;
  logic               rd_ok, wr_ok, raw_hit;
  logic               sel_wr;
  logic [1:0]         sel_size;
  logic [3:0]         sel_wstrb;
  logic [31:0]        sel_addr, sel_wdata;

  logic                ar_valid, aw_valid, w_valid;
  logic [AXI_ID_W-1:0] ar_id, aw_id;
  logic [31:0]         ar_addr, aw_addr, w_data;
  axi_size_t           ar_size, aw_size;
  logic [3:0]          w_strb;

  logic [RCNT_W-1:0]  rd_cnt [N_PORTS];
  logic [N_PORTS-1:0] r_hit, cnt_nz;
  logic [WCNT_W-1:0]  wr_cnt;
  wr_entry_t          wr_tab  [WR_DEPTH];
  wr_entry_t          tab_nxt [WR_DEPTH];
  logic               b_hit;
  int unsigned        b_idx, app_idx;
  logic               rd_err, wr_err;
  logic               unused_resp;

  bridge_arbiter #(.N_PORTS(N_PORTS)) u_arb (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign sel_wr    = wr[grant_idx];
  assign sel_size  = size[grant_idx];
  assign sel_wstrb = wstrb[grant_idx];
  assign sel_addr  = addr[grant_idx];
  assign sel_wdata = wdata[grant_idx];

  // Registered table only: a write retiring this cycle still blocks a matching read.
  always_comb begin
    raw_hit = 1'b0;
    for (int unsigned k = 0; k < WR_DEPTH; k++) begin
      if (wr_tab[k].valid && wr_tab[k].word_addr == sel_addr[31:2]) raw_hit = 1'b1;
    end
  end

  assign rd_ok   = (!ar_valid || axi.arready) && (rd_cnt[grant_idx] < RCNT_W'(RD_OUTSTANDING))
                   && !raw_hit;
  assign wr_ok   = !aw_valid && !w_valid && (wr_cnt < WCNT_W'(WR_DEPTH));
  assign accept  = resetn && (|grant) && (sel_wr ? wr_ok : rd_ok);
  assign rd_acc  = accept && !sel_wr;
  assign wr_acc  = accept && sel_wr;
  assign addr_ok = accept ? grant : '0;

  // Responses steer straight back to the port named by the AXI ID.
  always_comb begin
    r_hit   = '0;
    cnt_nz  = '0;
    data_ok = '0;
    rdata   = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      r_hit[p]   = axi.rvalid && (axi.rid == AXI_ID_W'(p));
      cnt_nz[p]  = (rd_cnt[p] != '0);
      data_ok[p] = r_hit[p] || (axi.bvalid && (axi.bid == AXI_ID_W'(p)));
      rdata[p]   = r_hit[p] ? axi.rdata : '0;
    end
  end

  // A response is retired against the oldest table entry of its ID; the table stays
  // packed oldest-first so per-ID order falls out of the global order.
  always_comb begin
    tab_nxt = wr_tab;
    b_hit   = 1'b0;
    b_idx   = 0;
    for (int unsigned k = 0; k < WR_DEPTH; k++) begin
      if (!b_hit && axi.bvalid && wr_tab[k].valid && (wr_tab[k].id == axi.bid)) begin
        b_hit = 1'b1;
        b_idx = k;
      end
    end
    if (b_hit) begin
      for (int unsigned k = 0; k + 1 < WR_DEPTH; k++) begin
        if (k >= b_idx) tab_nxt[k] = wr_tab[k + 1];
      end
      tab_nxt[WR_DEPTH - 1] = '0;
    end
    app_idx = 32'(wr_cnt) - (b_hit ? 32'd1 : 32'd0);
    if (wr_acc) begin
      for (int unsigned k = 0; k < WR_DEPTH; k++) begin
        if (k == app_idx) begin
          tab_nxt[k] = '{valid: 1'b1, id: AXI_ID_W'(grant_idx), word_addr: sel_addr[31:2]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_valid <= 1'b0;
      ar_id    <= '0;
      ar_addr  <= '0;
      ar_size  <= AXI_SIZE_BYTE;
    end else if (rd_acc) begin
      ar_valid <= 1'b1;
      ar_id    <= AXI_ID_W'(grant_idx);
      ar_addr  <= sel_addr;
      ar_size  <= axi_size_t'({1'b0, sel_size});
    end else if (axi.arready) begin
      ar_valid <= 1'b0;
    end
  end

  // AW and W load together but drop independently on their own handshakes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_valid <= 1'b0;
      w_valid  <= 1'b0;
      aw_id    <= '0;
      aw_addr  <= '0;
      aw_size  <= AXI_SIZE_BYTE;
      w_data   <= '0;
      w_strb   <= '0;
    end else if (wr_acc) begin
      aw_valid <= 1'b1;
      w_valid  <= 1'b1;
      aw_id    <= AXI_ID_W'(grant_idx);
      aw_addr  <= sel_addr;
      aw_size  <= axi_size_t'({1'b0, sel_size});
      w_data   <= sel_wdata;
      w_strb   <= sel_wstrb;
    end else begin
      if (axi.awready) aw_valid <= 1'b0;
      if (axi.wready)  w_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned p = 0; p < N_PORTS; p++) rd_cnt[p] <= '0;
      for (int unsigned k = 0; k < WR_DEPTH; k++) wr_tab[k] <= '0;
      wr_cnt <= '0;
    end else begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        if (rd_acc && grant[p] && !(r_hit[p] && cnt_nz[p])) begin
          rd_cnt[p] <= rd_cnt[p] + RCNT_W'(1);
        end else if (!(rd_acc && grant[p]) && r_hit[p] && cnt_nz[p]) begin
          rd_cnt[p] <= rd_cnt[p] - RCNT_W'(1);
        end
      end
      wr_tab <= tab_nxt;
      if (wr_acc && !b_hit)      wr_cnt <= wr_cnt + WCNT_W'(1);
      else if (!wr_acc && b_hit) wr_cnt <= wr_cnt - WCNT_W'(1);
    end
  end

  assign rd_err = axi.rvalid && ((r_hit & cnt_nz) == '0);
  assign wr_err = axi.bvalid && !b_hit;

  rd_resp_has_outstanding: assert property (@(posedge clk) disable iff (!resetn) !rd_err);
  wr_resp_has_outstanding: assert property (@(posedge clk) disable iff (!resetn) !wr_err);

  assign axi.arid    = ar_id;
  assign axi.araddr  = ar_addr;
  assign axi.arlen   = AXI_LEN_SINGLE;
  assign axi.arsize  = ar_size;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arlock  = '0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;
  assign axi.arvalid = ar_valid;
  assign axi.rready  = 1'b1;

  assign axi.awid    = aw_id;
  assign axi.awaddr  = aw_addr;
  assign axi.awlen   = AXI_LEN_SINGLE;
  assign axi.awsize  = aw_size;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.awlock  = '0;
  assign axi.awcache = '0;
  assign axi.awprot  = '0;
  assign axi.awvalid = aw_valid;

  assign axi.wid    = aw_id;
  assign axi.wdata  = w_data;
  assign axi.wstrb  = w_strb;
  assign axi.wlast  = 1'b1;
  assign axi.wvalid = w_valid;
  assign axi.bready = 1'b1;

  assign unused_resp = ^{axi.rresp, axi.rlast, axi.bresp};

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Directed bench for axi_sram_bridge; the bench plays the AXI slave by hand.
module tb_axi_sram_bridge;
  import axi_bridge_pkg::*;

  localparam int unsigned N = 2;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic [N-1:0]          req, wr;
  logic [N-1:0][1:0]     size;
  logic [N-1:0][3:0]     wstrb;
  logic [N-1:0][31:0]    addr, wdata;
  logic [N-1:0]          addr_ok, data_ok;
  logic [N-1:0][31:0]    rdata;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [N-1:0] exp_ok;
  int unsigned  prev_id, cur_id;

  axi_sram_bridge_if bus ();

  axi_sram_bridge #(.N_PORTS(2), .RD_OUTSTANDING(4), .WR_DEPTH(2)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .wr      (wr),
    .size    (size),
    .wstrb   (wstrb),
    .addr    (addr),
    .wdata   (wdata),
    .addr_ok (addr_ok),
    .data_ok (data_ok),
    .rdata   (rdata),
    .axi     (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic set_rd(input int unsigned p, input logic [31:0] a);
    req[p] = 1'b1; wr[p] = 1'b0; addr[p] = a; size[p] = 2'd2;
  endtask

  task automatic set_wr(input int unsigned p, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] sz);
    req[p] = 1'b1; wr[p] = 1'b1; addr[p] = a; wdata[p] = d; wstrb[p] = s; size[p] = sz;
  endtask

  task automatic r_ret(input int unsigned id, input logic [31:0] d);
    logic [N-1:0] e;
    @(negedge clk);
    bus.rvalid = 1'b1; bus.rid = 4'(id); bus.rdata = d;
    #1;
    e = '0; e[id] = 1'b1;
    check("r_data_ok", 32'(data_ok), 32'(e));
    check("r_rdata", rdata[id], d);
    check("r_rdata_other", rdata[1 - id], 32'h0);
    @(posedge clk); #1 bus.rvalid = 1'b0;
  endtask

  task automatic b_ret(input int unsigned id);
    logic [N-1:0] e;
    @(negedge clk);
    bus.bvalid = 1'b1; bus.bid = 4'(id);
    #1;
    e = '0; e[id] = 1'b1;
    check("b_data_ok", 32'(data_ok), 32'(e));
    @(posedge clk); #1 bus.bvalid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    req = '0; wr = '0; size = '0; wstrb = '0; addr = '0; wdata = '0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0;
    bus.rlast = 1'b1; bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
    bus.bid = '0; bus.bresp = '0;

    // Reset state, with a request present that must not be acknowledged
    repeat (2) @(negedge clk);
    set_rd(0, 32'h0000_0040);
    #1;
    check("rst_addr_ok", 32'(addr_ok), 32'h0);
    check("rst_data_ok", 32'(data_ok), 32'h0);
    check("rst_rdata0", rdata[0], 32'h0);
    check("rst_arvalid", 32'(bus.arvalid), 32'h0);
    check("rst_awvalid", 32'(bus.awvalid), 32'h0);
    check("rst_wvalid", 32'(bus.wvalid), 32'h0);
    check("rst_rready", 32'(bus.rready), 32'h1);
    check("rst_bready", 32'(bus.bready), 32'h1);
    @(negedge clk);
    req = '0;
    resetn = 1'b1;

    // Arbitration with both ports requesting every cycle
    bus.arready = 1'b1;
    prev_id = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_rd(0, 32'h0000_0100 + 32'(k * 4));
      set_rd(1, 32'h0000_0200 + 32'(k * 4));
      #1;
`ifdef AXI_BRIDGE_RR_ARB_EN
      exp_ok = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_ok = 2'b01;
`endif
      cur_id = (exp_ok == 2'b10) ? 1 : 0;
      check("arb_grant", 32'(addr_ok), 32'(exp_ok));
      if (k > 0) check("arb_arid", 32'(bus.arid), prev_id);
      prev_id = cur_id;
    end
    @(negedge clk);
    req = '0;
    #1 check("arb_arid_last", 32'(bus.arid), prev_id);
    @(negedge clk);
    bus.arready = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef AXI_BRIDGE_RR_ARB_EN
      r_ret(k % 2, 32'h5A00_0000 + 32'(k));
`else
      r_ret(0, 32'h5A00_0000 + 32'(k));
`endif
    end

    // Single read, port 0, slave latency 3
    @(negedge clk);
    set_rd(0, 32'h1FC0_0000);
    #1 check("t1_addr_ok", 32'(addr_ok), 32'h1);
    @(negedge clk);
    req = '0;
    #1;
    check("t1_arvalid", 32'(bus.arvalid), 32'h1);
    check("t1_araddr", bus.araddr, 32'h1FC0_0000);
    check("t1_arid", 32'(bus.arid), 32'h0);
    check("t1_arsize", 32'(bus.arsize), 32'h2);
    check("t1_arlen", 32'(bus.arlen), 32'h0);
    check("t1_arburst", 32'(bus.arburst), 32'h1);
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    #1;
    check("t1_arvalid_drop", 32'(bus.arvalid), 32'h0);
    check("t1_no_early_data_ok", 32'(data_ok), 32'h0);
    r_ret(0, 32'hCAFE_0001);
    @(negedge clk);
    #1 check("t1_data_ok_pulse", 32'(data_ok), 32'h0);

    // Port 1: five back-to-back reads against a limit of four
    bus.arready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_rd(1, 32'h0000_2000 + 32'(k * 4));
      #1 check("t2_accept", 32'(addr_ok), (k < 4) ? 32'h2 : 32'h0);
    end
    @(negedge clk);
    #1 check("t2_stall", 32'(addr_ok), 32'h0);
    @(negedge clk);
    bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h0000_00A0;
    #1;
    check("t2_full_same_cycle", 32'(addr_ok), 32'h0);
    check("t2_data_ok", 32'(data_ok), 32'h2);
    check("t2_rdata", rdata[1], 32'h0000_00A0);
    @(negedge clk);
    bus.rvalid = 1'b0;
    #1;
    check("t2_fifth_accept", 32'(addr_ok), 32'h2);
    @(negedge clk);
    req = '0;
    #1;
    check("t2_araddr", bus.araddr, 32'h0000_2010);
    check("t2_arid", 32'(bus.arid), 32'h1);
    @(negedge clk);
    bus.arready = 1'b0;
    for (int k = 0; k < 4; k++) r_ret(1, 32'h0000_00B0 + 32'(k));

    // Read-after-write blocking on the same word
    bus.awready = 1'b1; bus.wready = 1'b1; bus.arready = 1'b1;
    @(negedge clk);
    set_wr(1, 32'h8000_0010, 32'h1234_5678, 4'hF, 2'd2);
    #1 check("t3_wr_accept", 32'(addr_ok), 32'h2);
    @(negedge clk);
    req = '0; wr = '0;
    set_rd(0, 32'h8000_0012);
    #1;
    check("t3_awvalid", 32'(bus.awvalid), 32'h1);
    check("t3_awaddr", bus.awaddr, 32'h8000_0010);
    check("t3_awid", 32'(bus.awid), 32'h1);
    check("t3_wvalid", 32'(bus.wvalid), 32'h1);
    check("t3_wdata", bus.wdata, 32'h1234_5678);
    check("t3_wid", 32'(bus.wid), 32'h1);
    check("t3_wlast", 32'(bus.wlast), 32'h1);
    check("t3_raw_stall", 32'(addr_ok), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check("t3_raw_stall", 32'(addr_ok), 32'h0);
    end
    @(negedge clk);
    addr[0] = 32'h8000_0020;
    #1 check("t3_other_word", 32'(addr_ok), 32'h1);
    @(negedge clk);
    addr[0] = 32'h8000_0012;
    #1;
    check("t3_raw_stall_again", 32'(addr_ok), 32'h0);
    check("t3_other_araddr", bus.araddr, 32'h8000_0020);
    r_ret(0, 32'h0000_00BB);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1 check("t3_raw_stall", 32'(addr_ok), 32'h0);
    end
    @(negedge clk);
    bus.bvalid = 1'b1; bus.bid = 4'd1;
    #1;
    check("t3_b_data_ok", 32'(data_ok), 32'h2);
    check("t3_stall_on_retire", 32'(addr_ok), 32'h0);
    @(negedge clk);
    bus.bvalid = 1'b0;
    #1 check("t3_released", 32'(addr_ok), 32'h1);
    @(negedge clk);
    req = '0;
    #1 check("t3_blocked_araddr", bus.araddr, 32'h8000_0012);
    r_ret(0, 32'h0000_00CC);

    // AW handshake at cycle 2, W at cycle 5; half-word strobes pass through
    bus.awready = 1'b0; bus.wready = 1'b0;
    @(negedge clk);
    set_wr(0, 32'h0000_1000, 32'h0000_BEEF, 4'b0011, 2'd1);
    #1 check("t5_accept", 32'(addr_ok), 32'h1);
    @(negedge clk);
    set_wr(0, 32'h0000_2000, 32'h0000_CAFE, 4'b1100, 2'd2);
    #1;
    check("t5_wstrb", 32'(bus.wstrb), 32'h3);
    check("t5_awsize", 32'(bus.awsize), 32'h1);
    check("t5_awaddr", bus.awaddr, 32'h0000_1000);
    check("t5_hold1", 32'(addr_ok), 32'h0);
    for (int c = 2; c < 6; c++) begin
      @(negedge clk);
      bus.awready = (c == 2);
      bus.wready  = (c == 5);
      #1 check("t5_hold", 32'(addr_ok), 32'h0);
      if (c == 3) check("t5_aw_only_drop", 32'({bus.awvalid, bus.wvalid}), 32'h1);
    end
    @(negedge clk);
    bus.wready = 1'b0;
    #1;
    check("t5_wvalid_drop", 32'(bus.wvalid), 32'h0);
    check("t5_second_accept", 32'(addr_ok), 32'h1);
    @(negedge clk);
    req = '0; wr = '0;
    bus.awready = 1'b1; bus.wready = 1'b1;
    #1;
    check("t5_awaddr2", bus.awaddr, 32'h0000_2000);
    check("t5_wstrb2", 32'(bus.wstrb), 32'hC);
    @(negedge clk);
    bus.awready = 1'b0; bus.wready = 1'b0;
    b_ret(0);
    b_ret(0);

    // Reset with three reads outstanding, then a fresh full-depth run
    bus.arready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      set_rd(0, 32'h0000_3000 + 32'(k * 4));
      #1 check("t6_pre_accept", 32'(addr_ok), 32'h1);
    end
    @(negedge clk);
    req = '0;
    resetn = 1'b0;
    #1;
    check("t6_rst_arvalid", 32'(bus.arvalid), 32'h0);
    check("t6_rst_awvalid", 32'(bus.awvalid), 32'h0);
    check("t6_rst_data_ok", 32'(data_ok), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_rd(0, 32'h0000_4000 + 32'(k * 4));
      #1 check("t6_fresh_accept", 32'(addr_ok), (k < 4) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    req = '0;
    #1 check("t6_araddr", bus.araddr, 32'h0000_400C);
    @(negedge clk);
    bus.arready = 1'b0;
    for (int k = 0; k < 4; k++) r_ret(0, 32'h0000_0D00 + 32'(k));

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
